// File: rtl/ram_port_arbiter_if.sv
// Client-side request/grant bus plus the RAM port of the two-client arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_port_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [1:0]         wr_req;
  logic [2*AW-1:0]    wr_addr;
  logic [2*WIDTH-1:0] wr_data;
  logic [1:0]         wr_gnt;
  logic [1:0]         rd_req;
  logic [2*AW-1:0]    rd_addr;
  logic [1:0]         rd_gnt;
  logic [1:0]         rd_valid;
  logic [WIDTH-1:0]   rd_data;
  logic               init_done;

  logic               ram_wr_en;
  logic [AW-1:0]      ram_wr_addr;
  logic [WIDTH-1:0]   ram_din;
  logic [AW-1:0]      ram_rd_addr;
  logic [WIDTH-1:0]   ram_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_dout,
    output wr_gnt, rd_gnt, rd_valid, rd_data, init_done,
           ram_wr_en, ram_wr_addr, ram_din, ram_rd_addr
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_dout,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, init_done,
           ram_wr_en, ram_wr_addr, ram_din, ram_rd_addr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-client round-robin arbiter in front of a simple dual-port RAM.
// Clears the RAM after reset, then arbitrates writes and reads independently.
module ram_port_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             wr_last_q, wr_last_d;
  logic             rd_last_q, rd_last_d;
  logic [1:0]       wr_gnt, rd_gnt;
  logic             ram_wr_en_q, ram_wr_en_d;
  logic [AW-1:0]    ram_wr_addr_q, ram_wr_addr_d;
  logic [WIDTH-1:0] ram_din_q, ram_din_d;
  logic [AW-1:0]    ram_rd_addr_q, ram_rd_addr_d;
  logic [1:0]       rd_v1_q, rd_v2_q;

  logic [AW-1:0]    wr_addr_c [2];
  logic [WIDTH-1:0] wr_data_c [2];
  logic [AW-1:0]    rd_addr_c [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      assign wr_addr_c[gi] = bus.wr_addr[gi*AW +: AW];
      assign wr_data_c[gi] = bus.wr_data[gi*WIDTH +: WIDTH];
      assign rd_addr_c[gi] = bus.rd_addr[gi*AW +: AW];
    end
  endgenerate

  // last = index of the client granted most recently; the other one wins a tie
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   rr_pick = 2'b01;
      2'b10:   rr_pick = 2'b10;
      2'b11:   rr_pick = last ? 2'b01 : 2'b10;
      default: rr_pick = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && cnt_q == LAST_ADDR) state_d = RUN;
  end

  always_comb begin
    cnt_d         = cnt_q;
    init_done_d   = init_done_q;
    wr_last_d     = wr_last_q;
    rd_last_d     = rd_last_q;
    wr_gnt        = 2'b00;
    rd_gnt        = 2'b00;
    ram_wr_en_d   = 1'b0;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_din_d     = '0;
    ram_rd_addr_d = ram_rd_addr_q;
    case (state_q)
      INIT: begin
        ram_wr_en_d   = 1'b1;
        ram_wr_addr_d = cnt_q;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) init_done_d = 1'b1;
      end
      default: begin
        wr_gnt = rr_pick(bus.wr_req, wr_last_q);
        rd_gnt = rr_pick(bus.rd_req, rd_last_q);
        if (|wr_gnt) begin
          wr_last_d     = wr_gnt[1];
          ram_wr_en_d   = 1'b1;
          ram_wr_addr_d = wr_addr_c[wr_gnt[1]];
          ram_din_d     = wr_data_c[wr_gnt[1]];
        end
        if (|rd_gnt) begin
          rd_last_d     = rd_gnt[1];
          ram_rd_addr_d = rd_addr_c[rd_gnt[1]];
        end
      end
    endcase
  end

  // Pointers reset to client 1 so that client 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      wr_last_q     <= 1'b1;
      rd_last_q     <= 1'b1;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_din_q     <= '0;
      ram_rd_addr_q <= '0;
      rd_v1_q       <= 2'b00;
      rd_v2_q       <= 2'b00;
    end else begin
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      wr_last_q     <= wr_last_d;
      rd_last_q     <= rd_last_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_din_q     <= ram_din_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      rd_v1_q       <= rd_gnt;
      rd_v2_q       <= rd_v1_q;
    end
  end

  assign bus.wr_gnt      = wr_gnt;
  assign bus.rd_gnt      = rd_gnt;
  assign bus.rd_valid    = rd_v2_q;
  assign bus.rd_data     = bus.ram_dout;
  assign bus.init_done   = init_done_q;
  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.ram_wr_addr = ram_wr_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.ram_rd_addr = ram_rd_addr_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-old dual-port RAM.
module tb_ram_port_arbiter;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  ram_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM filled with 0xF while reset is held so the clear sweep is observable
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'hF;
    end else if (bus.ram_wr_en) begin
      mem[bus.ram_wr_addr] <= bus.ram_din;
    end
    bus.ram_dout <= mem[bus.ram_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]    rr_exp   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [AW-1:0] wadr_exp [4] = '{3'd0, 3'd1, 3'd0, 3'd1};
  logic [AW-1:0] radr_exp [4] = '{3'd4, 3'd5, 3'd4, 3'd5};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    bus.wr_req  = 2'b11;
    bus.rd_req  = 2'b11;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    #2;
    check("rst_wr_en",     32'(bus.ram_wr_en),   32'h0);
    check("rst_init_done", 32'(bus.init_done),   32'h0);
    check("rst_rd_valid",  32'(bus.rd_valid),    32'h0);
    check("rst_wr_gnt",    32'(bus.wr_gnt),      32'h0);
    check("rst_rd_gnt",    32'(bus.rd_gnt),      32'h0);
    check("rst_rd_addr",   32'(bus.ram_rd_addr), 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear sweep with both clients requesting: no grants until RUN
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("sweep%0d_wr_gnt", i), 32'(bus.wr_gnt), 32'h0);
      check($sformatf("sweep%0d_rd_gnt", i), 32'(bus.rd_gnt), 32'h0);
      tick();
      check($sformatf("sweep%0d_wr_en", i),  32'(bus.ram_wr_en),   32'h1);
      check($sformatf("sweep%0d_addr", i),   32'(bus.ram_wr_addr), 32'(i));
      check($sformatf("sweep%0d_din", i),    32'(bus.ram_din),     32'h0);
      check($sformatf("sweep%0d_done", i),   32'(bus.init_done),   (i == DEPTH-1) ? 32'h1 : 32'h0);
    end
    bus.wr_req = 2'b00;
    bus.rd_req = 2'b00;
    tick();
    check("idle_wr_en", 32'(bus.ram_wr_en), 32'h0);
    check("idle_din",   32'(bus.ram_din),   32'h0);

    // Write contention: alternate grants starting with client 0
    bus.wr_addr = {3'd1, 3'd0};
    bus.wr_data = {4'h2, 4'h1};
    bus.wr_req  = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_rr%0d_gnt", k), 32'(bus.wr_gnt), 32'(rr_exp[k]));
      tick();
      check($sformatf("wr_rr%0d_addr", k), 32'(bus.ram_wr_addr), 32'(wadr_exp[k]));
    end
    bus.wr_req = 2'b00;

    // Read contention
    bus.rd_addr = {3'd5, 3'd4};
    bus.rd_req  = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rd_rr%0d_gnt", k), 32'(bus.rd_gnt), 32'(rr_exp[k]));
      tick();
      check($sformatf("rd_rr%0d_addr", k), 32'(bus.ram_rd_addr), 32'(radr_exp[k]));
    end
    bus.rd_req = 2'b00;
    tick();
    tick();
    tick();
    check("drain_rd_valid", 32'(bus.rd_valid), 32'h0);

    // Client 0 writes 0xA to addr 3, client 1 reads it back
    bus.wr_addr = {3'd0, 3'd3};
    bus.wr_data = {4'h0, 4'hA};
    bus.wr_req  = 2'b01;
    #1;
    check("wb_wr_gnt", 32'(bus.wr_gnt), 32'h1);
    tick();
    check("wb_wr_en",   32'(bus.ram_wr_en),   32'h1);
    check("wb_wr_addr", 32'(bus.ram_wr_addr), 32'h3);
    check("wb_din",     32'(bus.ram_din),     32'hA);
    bus.wr_req  = 2'b00;
    bus.rd_addr = {3'd3, 3'd0};
    bus.rd_req  = 2'b10;
    #1;
    check("wb_rd_gnt", 32'(bus.rd_gnt), 32'h2);
    tick();
    bus.rd_req = 2'b00;
    check("wb_rd_addr",  32'(bus.ram_rd_addr), 32'h3);
    check("wb_valid_n1", 32'(bus.rd_valid),    32'h0);
    tick();
    check("wb_valid_n2", 32'(bus.rd_valid), 32'h2);
    check("wb_rd_data",  32'(bus.rd_data),  32'hA);
    tick();
    check("wb_valid_end", 32'(bus.rd_valid), 32'h0);

    // Same-cycle write/read of addr 2 returns old data; re-read returns new
    bus.wr_addr = {3'd0, 3'd2};
    bus.wr_data = {4'h0, 4'h5};
    bus.rd_addr = {3'd0, 3'd2};
    bus.wr_req  = 2'b01;
    bus.rd_req  = 2'b01;
    #1;
    check("col_wr_gnt", 32'(bus.wr_gnt), 32'h1);
    check("col_rd_gnt", 32'(bus.rd_gnt), 32'h1);
    tick();
    check("col_wr_en",   32'(bus.ram_wr_en),   32'h1);
    check("col_din",     32'(bus.ram_din),     32'h5);
    check("col_rd_addr", 32'(bus.ram_rd_addr), 32'h2);
    bus.wr_req = 2'b00;
    #1;
    check("col_rd_gnt2", 32'(bus.rd_gnt), 32'h1);
    tick();
    bus.rd_req = 2'b00;
    check("col_valid1", 32'(bus.rd_valid), 32'h1);
    check("col_old",    32'(bus.rd_data),  32'h0);
    tick();
    check("col_valid2", 32'(bus.rd_valid), 32'h1);
    check("col_new",    32'(bus.rd_data),  32'h5);
    tick();
    check("col_valid_end", 32'(bus.rd_valid), 32'h0);

    // Reset with a read in flight
    bus.rd_addr = {3'd3, 3'd0};
    bus.rd_req  = 2'b10;
    #1;
    check("rst_fl_gnt", 32'(bus.rd_gnt), 32'h2);
    tick();
    bus.rd_req = 2'b00;
    tick();
    check("rst_fl_valid_pre", 32'(bus.rd_valid), 32'h2);
    rst_n = 1'b0;
    #1;
    check("rst_fl_valid", 32'(bus.rd_valid),    32'h0);
    check("rst_fl_done",  32'(bus.init_done),   32'h0);
    check("rst_fl_raddr", 32'(bus.ram_rd_addr), 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("resweep0_en",    32'(bus.ram_wr_en),   32'h1);
    check("resweep0_addr",  32'(bus.ram_wr_addr), 32'h0);
    check("resweep0_valid", 32'(bus.rd_valid),    32'h0);
    check("resweep0_done",  32'(bus.init_done),   32'h0);
    tick();
    check("resweep1_addr",  32'(bus.ram_wr_addr), 32'h1);
    check("resweep1_valid", 32'(bus.rd_valid),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
